// File: rtl/sync_fifo_flags_if.sv
// Write/read/status bundle for sync_fifo_flags. The FIFO is the slave and the
// producer/consumer side is the master. clk and reset are separate scalar ports.
interface sync_fifo_flags_if #(
    parameter int DATA_DEPTH = 8,
    parameter int DATA_WIDTH = 32
);
    localparam int CNT_W = $clog2(DATA_DEPTH + 1);

    // Handshake: a write is taken on a rising edge when write_en && (!full || read_en);
    // a read is taken when read_en && !empty, and its data appears on dout with
    // dout_valid high for exactly the following cycle.
    logic [DATA_WIDTH-1:0] din;
    logic                  write_en;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output din, write_en, read_en,
        input  dout, dout_valid, empty, full, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  din, write_en, read_en,
        output dout, dout_valid, empty, full, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO that uses every entry, with registered dout and count-derived flags.
// Define SYNC_FIFO_FLAGS_ERR_EN to build the sticky overflow/underflow flags.
module sync_fifo_flags #(
    parameter int DATA_DEPTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int AF_LEVEL   = DATA_DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input logic              clk,
    input logic              reset,
    sync_fifo_flags_if.slave fifo
);
    localparam int PTR_W = $clog2(DATA_DEPTH);
    localparam int CNT_W = $clog2(DATA_DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DATA_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;

    logic empty_w;
    logic full_w;
    logic wr_ok;
    logic rd_ok;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CNT_FULL);

    // When full, a concurrent read frees the slot the write lands in.
    assign wr_ok = fifo.write_en && (!full_w || fifo.read_en);
    assign rd_ok = fifo.read_en && !empty_w;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = rd_ok;

        if (wr_ok) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            dout_d   = mem_q[rd_ptr_q];
        end

        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Storage has no reset; stale words are unreachable while count is zero.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem_q[wr_ptr_q] <= fifo.din;
        end
    end

`ifdef SYNC_FIFO_FLAGS_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (fifo.write_en & ~wr_ok);
        underflow_d = underflow_q | (fifo.read_en & empty_w);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign fifo.overflow  = overflow_q;
    assign fifo.underflow = underflow_q;
`else
    assign fifo.overflow  = 1'b0;
    assign fifo.underflow = 1'b0;
`endif

    assign fifo.dout         = dout_q;
    assign fifo.dout_valid   = dout_valid_q;
    assign fifo.count        = count_q;
    assign fifo.empty        = empty_w;
    assign fifo.full         = full_w;
    assign fifo.almost_full  = (count_q >= CNT_AF);
    assign fifo.almost_empty = (count_q <= CNT_AE);

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter DATA_DEPTH, default 8: number of storage entries, any integer >= 2; power of two not required.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: bits per entry.
REQ-003 SHALL have parameter AF_LEVEL, default DATA_DEPTH-1: almost_full threshold, legal range 1..DATA_DEPTH.
REQ-004 SHALL have parameter AE_LEVEL, default 1: almost_empty threshold, legal range 0..DATA_DEPTH-1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port din, input, DATA_WIDTH bits: write data.
REQ-008 SHALL have port write_en, input, 1 bit: write request.
REQ-009 SHALL have port read_en, input, 1 bit: read request.
REQ-010 SHALL have port dout, output, DATA_WIDTH bits: registered read data.
REQ-011 SHALL have port dout_valid, output, 1 bit: dout was loaded by the previous edge.
REQ-012 SHALL have port empty, output, 1 bit: count == 0.
REQ-013 SHALL have port full, output, 1 bit: count == DATA_DEPTH.
REQ-014 SHALL have port almost_full, output, 1 bit: count >= AF_LEVEL.
REQ-015 SHALL have port almost_empty, output, 1 bit: count <= AE_LEVEL.
REQ-016 SHALL have port count, output, $clog2(DATA_DEPTH+1) bits: current occupancy.
REQ-017 SHALL have ports overflow and underflow, output, 1 bit each: sticky error flags.

Function
REQ-018 SHALL use all DATA_DEPTH entries; no entry is sacrificed to distinguish full from empty.
REQ-019 SHALL accept a write iff write_en && (!full || read_en); an accepted write stores din at the write pointer.
REQ-020 SHALL accept a read iff read_en && !empty; no read-through of same-cycle write data when empty.
REQ-021 SHALL, on an accepted read, load dout with the entry at the read pointer on that edge and assert dout_valid for exactly the following cycle (1-cycle latency).
REQ-022 SHALL hold dout unchanged when no read is accepted; dout_valid is 0 in that cycle.
REQ-023 SHALL advance each pointer by 1 per accepted operation, wrapping DATA_DEPTH-1 -> 0 (non-power-of-two safe).
REQ-024 SHALL update count +1 (write only), -1 (read only), unchanged (both or neither); count never leaves 0..DATA_DEPTH.
REQ-025 SHALL, when full with read_en and write_en both high, accept both; count stays DATA_DEPTH and ordering is preserved.
REQ-026 SHALL, when empty with both high, accept only the write; count becomes 1.
REQ-027 SHALL derive empty, full, almost_full and almost_empty combinationally from registered count only.

Reset
REQ-028 SHALL, on reset high at a rising edge, set pointers and count to 0, dout to 0, dout_valid to 0, overflow and underflow to 0; empty=1, almost_empty=1, full=0, almost_full=0.
REQ-029 SHALL give reset priority over simultaneous read_en/write_en; requests in a reset cycle are discarded.
REQ-030 SHALL NOT reset storage contents; stale data is unreachable because count is 0.

Configuration
REQ-031 SHALL, with SYNC_FIFO_FLAGS_ERR_EN defined, set overflow on any cycle with write_en high and write rejected, and underflow on any cycle with read_en high and empty; both hold until reset.
REQ-032 SHALL, without SYNC_FIFO_FLAGS_ERR_EN, tie overflow and underflow to 0 and omit their logic; all other behaviour is identical.

Verification
REQ-033 SHALL cover fill/drain: DEPTH=6, write 6 words 0xA0..0xA5 -> full=1, count=6 after 6th edge; 6 reads -> dout 0xA0..0xA5 in order, each with dout_valid, then empty=1.
REQ-034 SHALL cover wrap: DEPTH=6, 4 writes, 4 reads, 5 writes 0xB0..0xB4, 5 reads -> dout 0xB0..0xB4, count returns to 0.
REQ-035 SHALL cover full simultaneous: full with 0xC0..0xC7 (DEPTH=8), read+write 0xD0 -> dout=0xC0, count stays 8; 8 reads -> 0xC1..0xC7 then 0xD0.
REQ-036 SHALL cover thresholds: DEPTH=8, AF_LEVEL=6, AE_LEVEL=2 -> almost_empty high at count 0..2, low at 3; almost_full low at 5, high at 6..8.
REQ-037 SHALL cover errors with SYNC_FIFO_FLAGS_ERR_EN: write_en when full without read_en -> overflow=1, count unchanged; read_en when empty -> underflow=1, dout unchanged; both clear only on reset.
REQ-038 SHALL cover reset mid-operation: count=3, reset with write_en=1 -> next cycle count=0, empty=1, dout_valid=0, dout=0.
